// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, debug and data-memory signals around dmem_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_err;
    logic          cpu_stall;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ack;
    logic          dbg_err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Handshake: a requester holds req/we/addr/wdata stable until its one-cycle
    // ack; req still high on the edge after ack is a new request.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack, dbg_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack, dbg_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// and the debug port; each access runs IDLE -> ACC -> RESP (misaligned skips ACC).
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_arbiter_if.slave        bus,
    output logic [1:0]           state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          grant_dbg;
    logic [DW-1:0] rdata_v;

    // last resets to DBG so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        we_d      = we_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        grant_dbg = bus.dbg_req & (~bus.cpu_req | ~last_q);
        case (state_q)
            IDLE: begin
                if (bus.cpu_req | bus.dbg_req) begin
                    sel_d   = grant_dbg;
                    last_d  = grant_dbg;
                    we_d    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
                    addr_d  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
                    wdata_d = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                    if (addr_d[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                state_d = RESP;
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_err   = 1'b0;
        bus.cpu_rdata = '0;
        bus.dbg_ack   = 1'b0;
        bus.dbg_err   = 1'b0;
        bus.dbg_rdata = '0;
        rdata_v       = (err_q | we_q) ? '0 : bus.mem_rdata;
        case (state_q)
            ACC: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
            end
            RESP: begin
                if (sel_q) begin
                    bus.dbg_ack   = 1'b1;
                    bus.dbg_err   = err_q;
                    bus.dbg_rdata = rdata_v;
                end else begin
                    bus.cpu_ack   = 1'b1;
                    bus.cpu_err   = err_q;
                    bus.cpu_rdata = rdata_v;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
    assign state_o       = state_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and access sequencer sharing the single-port data memory between the CPU load/store port and a debug port (bench/host memory inspection and preload). Sits between the CPU datapath and `Data_Memory`. Each access runs a fixed three-state sequence. Round-robin arbitration resolves conflicts. A stall output freezes the CPU PC while its access is pending.

## Interface
- `AW`, 32, address width (byte address)
- `DW`, 32, data width (one little-endian word, byte 0 at lowest address)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU access request; held with address/data stable until `cpu_ack`
- `cpu_we`  in  1  1 = store word, 0 = load word
- `cpu_addr`  in  AW  CPU byte address
- `cpu_wdata`  in  DW  CPU store data
- `cpu_rdata`  out  DW  load data, valid only while `cpu_ack`=1 for a read
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_err`  out  1  with `cpu_ack`: misaligned address, no memory access made
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack` (combinational)
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`, `dbg_err`  same directions, widths and meanings as the CPU set
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable (only with `mem_en`)
- `mem_addr`  out  AW  word-aligned address to memory
- `mem_wdata`  out  DW  write data to memory
- `mem_rdata`  in  DW  memory read data, valid the cycle after `mem_en`&`~mem_we`, held until next access

## Operation
- States: IDLE, ACC, RESP. Registers: `state`, `sel` (0=CPU, 1=DBG), `last` (last granted), latched `we`/`addr`/`wdata`, `err`.
- IDLE:
  - No requests: stay.
  - One request: grant it.
  - Both requesting: grant the one not equal to `last`.
  - On grant: latch that port's `we`/`addr`/`wdata` and set `sel`, `last`.
  - If `addr[1:0]`≠0, set `err`=1 and go to RESP directly. Otherwise go to ACC.
- ACC: `mem_en`=1, `mem_we`=latched `we`, `mem_addr`=latched addr, `mem_wdata`=latched data. Always go to RESP.
- RESP:
  - Pulse ack of `sel` port, and its `*_err`=`err`.
  - `*_rdata` = `mem_rdata` for a non-error read, else 0.
  - Other port's ack/err/rdata = 0. Clear `err`. Go to IDLE.
- Request still high on the edge after its ack cycle counts as a new request. Requesters drop `req` in the cycle after ack unless issuing another access.
- Non-selected port's inputs are ignored. Changing them mid-access has no effect.
- `mem_*` outputs are 0 in IDLE and RESP. Memory is never accessed for an errored request.

## Timing
- Reset (async, immediate): `state`=IDLE, `sel`=0, `last`=DBG so the CPU wins the first tie, `err`=0, latched regs 0.
  - Outputs on reset: `cpu_ack`=`dbg_ack`=0, `*_err`=0, `*_rdata`=0, `mem_en`=`mem_we`=0, `mem_addr`=`mem_wdata`=0.
  - Reset mid-access aborts it: no ack is issued, and `mem_en` drops asynchronously.
- Aligned access, req first high in cycle N (state IDLE): ACC in N+1 (`mem_en`=1), ack in N+2. Latency is 2 cycles after sampling; one access per 3 cycles per port.
- Misaligned access: ack with err in N+1.
- Request arriving while busy waits. It is granted from the IDLE following the current RESP, so worst-case wait is one full foreign access.
- Simultaneous requests alternate strictly: CPU, DBG, CPU, DBG…
- `cpu_stall` is high in N, N+1 and low in N+2 (ack cycle). The CPU advances PC on the N+2 edge.

## Test plan
- Reset, then CPU store 0xDEADBEEF to 0x08 → `mem_en`=`mem_we`=1 with `mem_addr`=0x08 exactly one cycle. `cpu_ack` one cycle later, `cpu_err`=0. Bytes mem[11..8]=DE AD BE EF.
- CPU load from 0x08 → `cpu_rdata`=0xDEADBEEF during the `cpu_ack` cycle. `cpu_stall` high exactly 2 cycles.
- Both requesters held high for 4 accesses from reset → grant order CPU, DBG, CPU, DBG. Acks never overlap. 12 cycles total.
- DBG load from 0x0E → `dbg_ack`=`dbg_err`=1 one cycle after sampling. `mem_en` never asserted, `dbg_rdata`=0.
- DBG store pending while CPU access is in ACC → CPU acked first, DBG granted from the next IDLE. DBG inputs altered during the CPU access do not reach `mem_*`.
- Assert `rst_n`=0 during ACC of a store → `mem_en` falls immediately, no ack. After release, state IDLE and the first tie goes to CPU.
